// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle logic ops, shift-add multiply, restoring divide
module alu_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [3:0]     op,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result,
    output logic           flag_neg,
    output logic           flag_zero,
    output logic           flag_carry,
    output logic           flag_over,
    output logic           flag_err
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [3:0]     op_r;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   rem_r;
    logic [N-1:0]   quo;

    logic [2*N-1:0] acc_next;
    logic [N:0]     shifted;
    logic           fits;
    logic [N-1:0]   rem_next;
    logic [N-1:0]   quo_next;
    logic           last;
    logic [N:0]     sum;
    logic [N-1:0]   diff;
    logic [2*N-1:0] res_c;
    logic           neg_c;
    logic           carry_c;
    logic           over_c;
    logic           err_c;
    logic           fin_c;

    // One iteration of the multiply and divide datapaths; both advance every EXEC cycle
    always_comb begin
        acc_next = mplier[0] ? acc + mcand : acc;
        shifted  = {rem_r, quo[N-1]};
        fits     = (shifted >= {1'b0, b_r});
        rem_next = fits ? N'(shifted - {1'b0, b_r}) : shifted[N-1:0];
        quo_next = {quo[N-2:0], fits};
        last     = (cnt == CW'(N - 1));
        sum      = {1'b0, a_r} + {1'b0, b_r};
        diff     = a_r - b_r;
    end

    always_comb begin
        res_c   = '0;
        neg_c   = 1'b0;
        carry_c = 1'b0;
        over_c  = 1'b0;
        err_c   = 1'b0;
        fin_c   = 1'b1;
        case (op_r)
            OP_ADD: begin
                res_c   = {{(N-1){1'b0}}, sum};
                carry_c = sum[N];
                over_c  = (a_r[N-1] == b_r[N-1]) && (sum[N-1] != a_r[N-1]);
            end
            OP_SUB: begin
                res_c   = {{N{1'b0}}, diff};
                neg_c   = (a_r < b_r);
                carry_c = (a_r >= b_r);
                over_c  = (a_r[N-1] != b_r[N-1]) && (diff[N-1] != a_r[N-1]);
            end
            OP_MUL: begin
                fin_c  = last;
                res_c  = acc_next;
                over_c = |acc_next[2*N-1:N];
            end
            OP_DIV: begin
                if (b_r == '0) begin
                    res_c = {{N{1'b0}}, {N{1'b1}}};
                    err_c = 1'b1;
                end else begin
                    fin_c = last;
                    res_c = {{N{1'b0}}, quo_next};
                end
            end
            OP_MOD: begin
                if (b_r == '0) begin
                    res_c = {{N{1'b0}}, a_r};
                    err_c = 1'b1;
                end else begin
                    fin_c = last;
                    res_c = {{N{1'b0}}, rem_next};
                end
            end
            OP_AND: res_c = {{N{1'b0}}, a_r & b_r};
            OP_OR:  res_c = {{N{1'b0}}, a_r | b_r};
            OP_XOR: res_c = {{N{1'b0}}, a_r ^ b_r};
            OP_SHL: begin
                res_c   = {{N{1'b0}}, a_r[N-2:0], 1'b0};
                carry_c = a_r[N-1];
            end
            OP_SHR: begin
                res_c   = {{N{1'b0}}, 1'b0, a_r[N-1:1]};
                carry_c = a_r[0];
            end
            default: err_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            flag_neg   <= 1'b0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_over  <= 1'b0;
            flag_err   <= 1'b0;
            a_r        <= '0;
            b_r        <= '0;
            op_r       <= '0;
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            rem_r      <= '0;
            quo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        op_r   <= op;
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= {{N{1'b0}}, a};
                        mplier <= b;
                        rem_r  <= '0;
                        quo    <= a;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (fin_c) begin
                        result     <= res_c;
                        flag_neg   <= neg_c;
                        flag_zero  <= (res_c == '0);
                        flag_carry <= carry_c;
                        flag_over  <= over_c;
                        flag_err   <= err_c;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        rem_r  <= rem_next;
                        quo    <= quo_next;
                        cnt    <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed self-checking bench for alu_seq
module tb_alu_seq;

    localparam int N    = 4;
    localparam int MASK = (1 << N) - 1;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [3:0]     op;
    logic           busy;
    logic           done;
    logic [2*N-1:0] result;
    logic           flag_neg;
    logic           flag_zero;
    logic           flag_carry;
    logic           flag_over;
    logic           flag_err;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
        .busy(busy), .done(done), .result(result),
        .flag_neg(flag_neg), .flag_zero(flag_zero), .flag_carry(flag_carry),
        .flag_over(flag_over), .flag_err(flag_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= (1 << (N - 1))) ? v - (1 << N) : v;
    endfunction

    // Arithmetic reference: what each operation must produce and how many EXEC cycles it takes
    task automatic ref_op(input int x, input int y, input int o, output int r,
                          output bit ng, output bit c, output bit ov, output bit e,
                          output int lat);
        int s;
        r = 0; ng = 0; c = 0; ov = 0; e = 0; lat = 1;
        case (o)
            0: begin
                r = x + y; c = (r >> N) & 1;
                s = sgn(x) + sgn(y); ov = (s > MASK / 2) || (s < -(MASK / 2) - 1);
            end
            1: begin
                r = (x - y) & MASK; ng = (x < y); c = (x >= y);
                s = sgn(x) - sgn(y); ov = (s > MASK / 2) || (s < -(MASK / 2) - 1);
            end
            2: begin r = x * y; ov = (r > MASK); lat = N; end
            3: if (y == 0) begin r = MASK; e = 1; end else begin r = x / y; lat = N; end
            4: if (y == 0) begin r = x; e = 1; end else begin r = x % y; lat = N; end
            5: r = x & y;
            6: r = x | y;
            7: r = x ^ y;
            8: begin r = (x << 1) & MASK; c = (x >> (N - 1)) & 1; end
            9: begin r = x >> 1; c = x & 1; end
            default: e = 1;
        endcase
    endtask

    bit m_busy = 0, m_done = 0, m_neg = 0, m_zero = 0, m_carry = 0, m_over = 0, m_err = 0;
    int m_res = 0, m_left = 0;
    int p_res, p_lat;
    bit p_neg, p_carry, p_over, p_err;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_res = 0; m_left = 0;
            m_neg = 0; m_zero = 0; m_carry = 0; m_over = 0; m_err = 0;
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_res = p_res; m_neg = p_neg; m_carry = p_carry;
                m_over = p_over; m_err = p_err; m_zero = (p_res == 0);
            end
        end else if (start) begin
            ref_op(int'(a), int'(b), int'(op), p_res, p_neg, p_carry, p_over, p_err, p_lat);
            m_busy = 1;
            m_left = p_lat;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("result", 32'(result), 32'(m_res));
        chk("flag_neg", 32'(flag_neg), 32'(m_neg));
        chk("flag_zero", 32'(flag_zero), 32'(m_zero));
        chk("flag_carry", 32'(flag_carry), 32'(m_carry));
        chk("flag_over", 32'(flag_over), 32'(m_over));
        chk("flag_err", 32'(flag_err), 32'(m_err));
    end

    task automatic run_op(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                          input bit noisy, output int lat);
        @(posedge clk); #1;
        start = 1'b1; a = x; b = y; op = o;
        @(posedge clk); #1;
        start = noisy; a = N'($urandom); b = N'($urandom); op = 4'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat >= 2) start = 1'b0;
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    int lat;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        run_op(4'd0, 4'd9, 4'd8, 1'b0, lat);
        chk("add_lat", 32'(lat), 32'd1);
        chk("add_res", 32'(result), 32'h011);
        chk("add_carry", 32'(flag_carry), 32'd1);
        chk("add_over", 32'(flag_over), 32'd1);
        chk("add_zero", 32'(flag_zero), 32'd0);

        run_op(4'd1, 4'd3, 4'd5, 1'b0, lat);
        chk("sub_res", 32'(result[3:0]), 32'hE);
        chk("sub_neg", 32'(flag_neg), 32'd1);
        chk("sub_carry", 32'(flag_carry), 32'd0);

        run_op(4'd2, 4'd15, 4'd15, 1'b0, lat);
        chk("mul_lat", 32'(lat), 32'd4);
        chk("mul_res", 32'(result), 32'hE1);
        chk("mul_over", 32'(flag_over), 32'd1);

        run_op(4'd3, 4'd13, 4'd4, 1'b0, lat);
        chk("div_lat", 32'(lat), 32'd4);
        chk("div_res", 32'(result), 32'd3);
        run_op(4'd4, 4'd13, 4'd4, 1'b0, lat);
        chk("mod_res", 32'(result), 32'd1);
        run_op(4'd3, 4'd7, 4'd0, 1'b0, lat);
        chk("div0_lat", 32'(lat), 32'd1);
        chk("div0_res", 32'(result), 32'hF);
        chk("div0_err", 32'(flag_err), 32'd1);

        run_op(4'd8, 4'd9, 4'd0, 1'b0, lat);
        chk("shl_res", 32'(result), 32'd2);
        chk("shl_carry", 32'(flag_carry), 32'd1);

        // Abort a multiply in its second EXEC cycle
        @(posedge clk); #1;
        start = 1'b1; a = 4'd15; b = 4'd15; op = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done), 32'd0);
        end

        run_op(4'd3, 4'd13, 4'd4, 1'b1, lat);
        chk("noisy_div_res", 32'(result), 32'd3);
        run_op(4'd12, 4'd5, 4'd6, 1'b0, lat);
        chk("illegal_res", 32'(result), 32'd0);
        chk("illegal_err", 32'(flag_err), 32'd1);
        chk("illegal_zero", 32'(flag_zero), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            a = N'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            op = 4'($urandom);
            rst = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
